// File: rtl/sample_test_msaa_if.sv
// Request/result bundle for the MSAA subsample coverage tester.
// master drives requests and out_ready; slave is the tester.
interface sample_test_msaa_if #(
  parameter int SIGFIG  = 24,
  parameter int AXIS    = 3,
  parameter int COLORS  = 3,
  parameter int SAMPLES = 4
);
  logic [2:0][AXIS-1:0][SIGFIG-1:0]    tri_S;
  logic [COLORS-1:0][SIGFIG-1:0]       color_U;
  logic [1:0][SIGFIG-1:0]              pixel_S;
  logic [SAMPLES-1:0][1:0][SIGFIG-1:0] samp_S;
  logic [SAMPLES-1:0]                  samp_en;
  logic                                in_valid;
  logic                                in_ready;
  logic                                out_valid;
  logic                                out_ready;
  logic [AXIS-1:0][SIGFIG-1:0]         hit_S;
  logic [COLORS-1:0][SIGFIG-1:0]       color_out_U;
  logic [SAMPLES-1:0]                  hit_mask;
  logic                                hit_valid;

  modport master (
    output tri_S, color_U, pixel_S, samp_S,
    output samp_en, in_valid, out_ready,
    input  in_ready, out_valid, hit_S,
    input  color_out_U, hit_mask, hit_valid
  );

  modport slave (
    input  tri_S, color_U, pixel_S, samp_S,
    input  samp_en, in_valid, out_ready,
    output in_ready, out_valid, hit_S,
    output color_out_U, hit_mask, hit_valid
  );
endinterface

// File: rtl/sample_test_msaa.sv
// MSAA subsample tester: edge-function coverage per subsample.
// Define SAMPLE_TEST_BACKFACE_CULL_EN to reject back-facing hits.
module sample_test_msaa #(
  parameter int SIGFIG  = 24,
  parameter int RADIX   = 10,
  parameter int AXIS    = 3,
  parameter int COLORS  = 3,
  parameter int SAMPLES = 4
) (
  input logic clk,
  input logic rst,
  sample_test_msaa_if.slave io
);
  localparam int SHORTSF = SIGFIG - 7;
  localparam int DW = 2 * SHORTSF;
  localparam int IW = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;

  if (AXIS < 3 || SAMPLES < 1 || SAMPLES > 16 ||
      RADIX >= SHORTSF) begin : g_bad_cfg
    $error("sample_test_msaa: unsupported parameters");
  end

  typedef enum logic [1:0] {
    S_IDLE, S_TEST, S_DRAIN, S_OUT
  } state_t;

  state_t state;
  logic [IW-1:0] cnt;
  logic drn;

  logic [2:0][1:0][SIGFIG-1:0] vtx_q;
  logic [SIGFIG-1:0] z0_q;
  logic [1:0][SIGFIG-1:0] pix_q;
  logic [COLORS-1:0][SIGFIG-1:0] col_q;
  logic [SAMPLES-1:0][1:0][SIGFIG-1:0] samp_q;
  logic [SAMPLES-1:0] en_q;

  logic rdy_q, vld_q, hv_q;
  logic [SAMPLES-1:0] hm_q;
  logic [AXIS-1:0][SIGFIG-1:0] hs_q;
  logic [COLORS-1:0][SIGFIG-1:0] co_q;

  logic s1_vld, s1_en;
  logic [IW-1:0] s1_idx;
  logic signed [SHORTSF-1:0] s1_x [3];
  logic signed [SHORTSF-1:0] s1_y [3];

  logic s2_vld, s2_en;
  logic [IW-1:0] s2_idx;
  logic signed [DW-1:0] s2_d [3];

  logic [2:0] neg, zro;
  logic front, hit;
`ifndef SAMPLE_TEST_BACKFACE_CULL_EN
  logic back;
`endif
  logic [SAMPLES-1:0] acc, mask_nxt;

  assign io.in_ready    = rdy_q;
  assign io.out_valid   = vld_q;
  assign io.hit_valid   = hv_q;
  assign io.hit_mask    = hm_q;
  assign io.hit_S       = hs_q;
  assign io.color_out_U = co_q;

  // Sign classes of the edge functions and the coverage merge.
  always_comb begin
    for (int e = 0; e < 3; e++) begin
      neg[e] = s2_d[e][DW-1];
      zro[e] = (s2_d[e] == '0);
    end
    front = (neg[0] | zro[0]) & neg[1] &
            (neg[2] | zro[2]);
`ifdef SAMPLE_TEST_BACKFACE_CULL_EN
    hit = front;
`else
    back = !neg[0] & !neg[1] & !zro[1] & !neg[2];
    hit = front | back;
`endif
    mask_nxt = acc;
    if (s2_vld) mask_nxt[s2_idx] = s2_en & hit;
  end

  // Control FSM: capture, issue, drain, hold result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      drn    <= 1'b0;
      rdy_q  <= 1'b1;
      vld_q  <= 1'b0;
      hv_q   <= 1'b0;
      hm_q   <= '0;
      hs_q   <= '0;
      co_q   <= '0;
      vtx_q  <= '0;
      z0_q   <= '0;
      pix_q  <= '0;
      col_q  <= '0;
      samp_q <= '0;
      en_q   <= '0;
    end else begin
      unique case (state)
        S_IDLE: if (io.in_valid) begin
          for (int v = 0; v < 3; v++) begin
            vtx_q[v][0] <= io.tri_S[v][0];
            vtx_q[v][1] <= io.tri_S[v][1];
          end
          z0_q   <= io.tri_S[0][2];
          pix_q  <= io.pixel_S;
          col_q  <= io.color_U;
          samp_q <= io.samp_S;
          en_q   <= io.samp_en;
          cnt    <= '0;
          rdy_q  <= 1'b0;
          state  <= S_TEST;
        end
        S_TEST: begin
          if (cnt == IW'(SAMPLES - 1)) begin
            cnt   <= '0;
            drn   <= 1'b0;
            state <= S_DRAIN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DRAIN: begin
          drn <= 1'b1;
          if (drn) begin
            state   <= S_OUT;
            vld_q   <= 1'b1;
            hm_q    <= mask_nxt;
            hv_q    <= |mask_nxt;
            hs_q    <= '0;
            hs_q[0] <= pix_q[0];
            hs_q[1] <= pix_q[1];
            hs_q[2] <= z0_q;
            co_q    <= col_q;
          end
        end
        S_OUT: if (io.out_ready) begin
          vld_q <= 1'b0;
          rdy_q <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Two-stage edge pipeline: shift/truncate, then cross products.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_vld <= 1'b0;
      s1_en  <= 1'b0;
      s1_idx <= '0;
      s2_vld <= 1'b0;
      s2_en  <= 1'b0;
      s2_idx <= '0;
      acc    <= '0;
      for (int v = 0; v < 3; v++) begin
        s1_x[v] <= '0;
        s1_y[v] <= '0;
        s2_d[v] <= '0;
      end
    end else begin
      s1_vld <= (state == S_TEST);
      s1_idx <= cnt;
      s1_en  <= en_q[cnt];
      for (int v = 0; v < 3; v++) begin
        s1_x[v] <= SHORTSF'(vtx_q[v][0] - samp_q[cnt][0]);
        s1_y[v] <= SHORTSF'(vtx_q[v][1] - samp_q[cnt][1]);
      end
      s2_vld  <= s1_vld;
      s2_idx  <= s1_idx;
      s2_en   <= s1_en;
      s2_d[0] <= DW'(s1_x[0]) * DW'(s1_y[1]) -
                 DW'(s1_x[1]) * DW'(s1_y[0]);
      s2_d[1] <= DW'(s1_x[1]) * DW'(s1_y[2]) -
                 DW'(s1_x[2]) * DW'(s1_y[1]);
      s2_d[2] <= DW'(s1_x[2]) * DW'(s1_y[0]) -
                 DW'(s1_x[0]) * DW'(s1_y[2]);
      acc <= (state == S_IDLE) ? '0 : mask_nxt;
    end
  end
endmodule
